// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter.
//   rv32i_word   : 32-bit word type, the default address width
//   LINE_W       : cacheline width in bits
//   arb_state_t  : arbiter FSM state (IDLE, SERVE_I, SERVE_D)
//   arb_grant_t  : identifies a requester (GNT_I, GNT_D)
//   pick_grant() : round-robin tie-break between the two requesters
package cacheline_arbiter_pkg;

    typedef logic [31:0] rv32i_word;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

    // A lone requester always wins. On a tie the requester that was not
    // granted last time goes first, so neither side waits more than one
    // transaction of the other.
    function automatic arb_grant_t pick_grant(input logic       i_req,
                                              input logic       d_req,
                                              input arb_grant_t last);
        if (d_req && (!i_req || last == GNT_I)) begin
            return GNT_D;
        end
        return GNT_I;
    endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline-wide memory port between the I-cache (read only) and
// the D-cache (read / write-back). One line transaction is outstanding at a
// time; the granted request is latched so memory sees stable inputs for the
// whole transaction regardless of what the requester does meanwhile.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_read, i_address         I-cache line read request (level, held to i_resp)
//   i_rdata, i_resp           line data and 1-cycle completion to the I-cache
//   d_read, d_write           D-cache read / write-back request (level)
//   d_address, d_wdata        D-cache line address and write-back data
//   d_rdata, d_resp           line data and 1-cycle completion to the D-cache
//   pmem_read, pmem_write     registered memory command
//   pmem_address, pmem_wdata  latched address / data of the granted request
//   pmem_rdata, pmem_resp     memory read data and 1-cycle completion
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int ADDR_W = $bits(rv32i_word),
    parameter int LINE_W = cacheline_arbiter_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    arb_state_t state_next;
    arb_grant_t last_grant;
    arb_grant_t grant;
    logic       i_req;
    logic       d_req;
    logic       grant_valid;

    assign i_req       = i_read;
    assign d_req       = d_read | d_write;
    assign grant_valid = i_req | d_req;
    assign grant       = pick_grant(i_req, d_req, last_grant);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant == GNT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: completion is steered to the owner of the transaction in
    // the same cycle memory responds; a response while IDLE reaches nobody.
    always_comb begin
        i_resp = (state == SERVE_I) && pmem_resp;
        d_resp = (state == SERVE_D) && pmem_resp;
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Grant latch and registered memory command. Captured only on the
    // IDLE -> SERVE_x edge and then frozen until memory completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= GNT_I;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant;
                        if (grant == GNT_D) begin
                            // A simultaneous read and write-back is taken as
                            // the write-back.
                            pmem_write   <= d_write;
                            pmem_read    <= ~d_write;
                            pmem_address <= d_address;
                            pmem_wdata   <= d_wdata;
                        end else begin
                            pmem_write   <= 1'b0;
                            pmem_read    <= 1'b1;
                            pmem_address <= i_address;
                            pmem_wdata   <= '0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;
    import cacheline_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   model_last_d = 1'b0;   // requester granted last, per round-robin model

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_addr(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_i(input logic [AW-1:0] addr);
        exp_t e;
        i_read    = 1'b1;
        i_address = addr;
        e.is_d = 1'b0; e.wr = 1'b0; e.addr = addr; e.wdata = '0;
        sb.push_back(e);
    endtask

    task automatic push_d(input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        exp_t e;
        d_read    = rd;
        d_write   = wr;
        d_address = addr;
        d_wdata   = wdata;
        e.is_d = 1'b1; e.wr = wr; e.addr = addr; e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Both caches request in the same cycle; the model decides who goes first.
    task automatic tie(input logic [AW-1:0] ia, input logic [AW-1:0] da);
        if (!model_last_d) begin
            push_d(1'b1, 1'b0, da, '0);
            push_i(ia);
        end else begin
            push_i(ia);
            push_d(1'b1, 1'b0, da, '0);
        end
    endtask

    // Act as memory for the next transaction: wait for the command, compare it
    // with the scoreboard head, respond after 'latency' cycles, check delivery.
    task automatic serve(input int latency, input logic [LW-1:0] rdata, input bit scramble);
        exp_t e;
        bit   seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) seen = 1'b1;
        end
        check1("grant_seen", seen, 1'b1);
        if (!seen || sb.size() == 0) begin
            check1("sb_has_entry", sb.size() != 0, 1'b1);
            return;
        end
        e = sb.pop_front();
        check1("pmem_read", pmem_read, !e.wr);
        check1("pmem_write", pmem_write, e.wr);
        check_addr("pmem_address", pmem_address, e.addr);
        if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
        for (int k = 1; k < latency; k++) begin
            @(negedge clk);
            if (scramble) begin
                d_wdata   = {8{$urandom()}};
                d_address = $urandom();
            end
            #1;
            check1("hold_write", pmem_write, e.wr);
            check_addr("hold_address", pmem_address, e.addr);
            if (e.wr) check("hold_wdata", pmem_wdata, e.wdata);
            check1("early_i_resp", i_resp, 1'b0);
            check1("early_d_resp", d_resp, 1'b0);
        end
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        #1;
        check1("i_resp", i_resp, !e.is_d);
        check1("d_resp", d_resp, e.is_d);
        if (e.is_d) check("d_rdata", d_rdata, rdata);
        else        check("i_rdata", i_rdata, rdata);
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = {8{$urandom()}};
        if (e.is_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        model_last_d = e.is_d;
        @(negedge clk);
        check1("idle_read", pmem_read, 1'b0);
        check1("idle_write", pmem_write, 1'b0);
        check1("post_i_resp", i_resp, 1'b0);
        check1("post_d_resp", d_resp, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check1("rst_pmem_read", pmem_read, 1'b0);
        check1("rst_pmem_write", pmem_write, 1'b0);
        check_addr("rst_pmem_address", pmem_address, '0);
        check("rst_pmem_wdata", pmem_wdata, '0);
        check1("rst_i_resp", i_resp, 1'b0);
        check1("rst_d_resp", d_resp, 1'b0);
        rst = 1'b0;
        model_last_d = 1'b0;

        // 1: I-cache alone, command visible one cycle after the request
        @(negedge clk);
        push_i(32'h0000_1000);
        @(negedge clk);
        check1("t1_read_next_cycle", pmem_read, 1'b1);
        check_addr("t1_addr_next_cycle", pmem_address, 32'h0000_1000);
        serve(4, {32{8'hA5}}, 1'b0);

        // 2: round-robin over four ties with a lone D in between
        @(negedge clk);
        tie(32'h0000_0100, 32'h0000_0200);
        serve(2, {8{32'h1111_0001}}, 1'b0);
        serve(3, {8{32'h1111_0002}}, 1'b0);
        tie(32'h0000_0140, 32'h0000_0240);
        serve(1, {8{32'h2222_0001}}, 1'b0);
        serve(2, {8{32'h2222_0002}}, 1'b0);
        push_d(1'b1, 1'b0, 32'h0000_0280, '0);
        serve(2, {8{32'h3333_0001}}, 1'b0);
        tie(32'h0000_0180, 32'h0000_02C0);
        serve(2, {8{32'h4444_0001}}, 1'b0);
        serve(2, {8{32'h4444_0002}}, 1'b0);
        tie(32'h0000_01C0, 32'h0000_0300);
        serve(3, {8{32'h5555_0001}}, 1'b0);
        serve(1, {8{32'h5555_0002}}, 1'b0);

        // 3: write-back with requester data changing mid-transaction
        push_d(1'b0, 1'b1, 32'h0000_2040, {8{32'hDEAD_BEEF}});
        serve(5, {8{32'h6666_0001}}, 1'b1);

        // 4: read and write both high -> write
        push_d(1'b1, 1'b1, 32'h0000_3080, {8{32'hCAFE_F00D}});
        serve(2, {8{32'h7777_0001}}, 1'b0);

        // 5: reset in SERVE_D, then a late memory response
        d_read = 1'b1; d_write = 1'b0; d_address = 32'h0000_4000;
        @(negedge clk);
        check1("t5_read_granted", pmem_read, 1'b1);
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        check1("t5_read_cleared", pmem_read, 1'b0);
        check_addr("t5_addr_cleared", pmem_address, '0);
        rst = 1'b0;
        model_last_d = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {8{32'hBAD0_BAD0}};
        #1;
        check1("t5_late_i_resp", i_resp, 1'b0);
        check1("t5_late_d_resp", d_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        check1("t5_still_idle", pmem_read, 1'b0);

        // 6: stray response while IDLE, then a tie shows last_grant was reset
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        check1("t6_i_resp", i_resp, 1'b0);
        check1("t6_d_resp", d_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        check1("t6_no_cmd", pmem_read | pmem_write, 1'b0);
        tie(32'h0000_5000, 32'h0000_6000);
        serve(2, {8{32'h8888_0001}}, 1'b0);
        serve(2, {8{32'h8888_0002}}, 1'b0);

        check1("sb_empty", sb.size() == 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
